// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard and stall scheduler for the 5-stage core.
// It handles load-use bubbles, MUL/DIV occupancy with a watchdog, fetch
// bubbles on instruction-memory wait, and the taken-branch flush. It also
// keeps a saturating count of the cycles in which the PC was frozen.
//
// Handshake note: md_done is a one-cycle pulse from the MUL/DIV unit. It is
// honoured only in MD_BUSY; a pulse that arrives while in RUN is dropped.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_rs1,
    input  logic [4:0]       D_rs2,
    input  logic             D_uses_rs1,
    input  logic             D_uses_rs2,
    input  logic [4:0]       E_rd,
    input  logic             E_MemRead,
    input  logic             E_md_start,
    input  logic             md_done,
    input  logic             imem_ready,
    input  logic             E_branch_taken,
    input  logic             clr_cnt,
    output logic             D_PCWrite,
    output logic             D_IFIDWrite,
    output logic             D_Flush,
    output logic             E_Flush,
    output logic             E_Hold,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             dbg_state_o
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam int               MD_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MD_W-1:0]  MD_LAST = MD_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             md_timeout_q, md_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;

    // A load in EX feeding a register the ID instruction really reads (x0 never hazards).
    assign load_use = E_MemRead && (E_rd != 5'd0) &&
                      ((D_uses_rs1 && (D_rs1 == E_rd)) ||
                       (D_uses_rs2 && (D_rs2 == E_rd)));

    // Next-state and stall/flush decode; RUN uses branch > mul/div > load-use > fetch wait.
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        D_PCWrite    = 1'b1;
        D_IFIDWrite  = 1'b1;
        D_Flush      = 1'b0;
        E_Flush      = 1'b0;
        E_Hold       = 1'b0;
        if (rst) begin
            D_PCWrite   = 1'b0;
            D_IFIDWrite = 1'b0;
            D_Flush     = 1'b1;
            E_Flush     = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (E_branch_taken) begin
                        D_Flush = 1'b1;
                        E_Flush = 1'b1;
                    end else if (E_md_start) begin
                        D_PCWrite   = 1'b0;
                        D_IFIDWrite = 1'b0;
                        E_Hold      = 1'b1;
                        state_d     = MD_BUSY;
                        md_cnt_d    = '0;
                    end else if (load_use) begin
                        D_PCWrite   = 1'b0;
                        D_IFIDWrite = 1'b0;
                        E_Flush     = 1'b1;
                    end else if (!imem_ready) begin
                        D_PCWrite = 1'b0;
                        D_Flush   = 1'b1;
                    end
                end
                MD_BUSY: begin
                    D_PCWrite   = 1'b0;
                    D_IFIDWrite = 1'b0;
                    E_Hold      = 1'b1;
                    if (md_done) begin
                        state_d = RUN;
                    end else if (md_cnt_q == MD_LAST) begin
                        md_timeout_d = 1'b1;
                        state_d      = RUN;
                    end else begin
                        md_cnt_d = md_cnt_q + MD_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Stall-cycle counter: a clear wins over counting, and the count sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
        end else if (!D_PCWrite && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign md_timeout  = md_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign dbg_state_o = (state_q == MD_BUSY);

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (MD_TIMEOUT=64/CNT_W=16 and
// MD_TIMEOUT=4/CNT_W=4) share one set of inputs and are checked against a
// behavioural model every cycle, plus vector tables and directed sequences.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] D_rs1, D_rs2, E_rd;
  logic       D_uses_rs1, D_uses_rs2, E_MemRead, E_md_start, md_done;
  logic       imem_ready, E_branch_taken, clr_cnt;

  logic        pcw_l, ifidw_l, dfl_l, efl_l, hold_l, tmo_l, dbg_l;
  logic [15:0] sc_l;
  logic        pcw_s, ifidw_s, dfl_s, efl_s, hold_s, tmo_s, dbg_s;
  logic [3:0]  sc_s;

  int checks = 0;
  int errors = 0;
  int hold_tally_l = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  hazard_stall_ctrl #(.MD_TIMEOUT(64), .CNT_W(16)) u_big (
    .clk(clk), .rst(rst), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_uses_rs1(D_uses_rs1), .D_uses_rs2(D_uses_rs2), .E_rd(E_rd),
    .E_MemRead(E_MemRead), .E_md_start(E_md_start), .md_done(md_done),
    .imem_ready(imem_ready), .E_branch_taken(E_branch_taken), .clr_cnt(clr_cnt),
    .D_PCWrite(pcw_l), .D_IFIDWrite(ifidw_l), .D_Flush(dfl_l), .E_Flush(efl_l),
    .E_Hold(hold_l), .md_timeout(tmo_l), .stall_cnt(sc_l), .dbg_state_o(dbg_l)
  );

  hazard_stall_ctrl #(.MD_TIMEOUT(4), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_uses_rs1(D_uses_rs1), .D_uses_rs2(D_uses_rs2), .E_rd(E_rd),
    .E_MemRead(E_MemRead), .E_md_start(E_md_start), .md_done(md_done),
    .imem_ready(imem_ready), .E_branch_taken(E_branch_taken), .clr_cnt(clr_cnt),
    .D_PCWrite(pcw_s), .D_IFIDWrite(ifidw_s), .D_Flush(dfl_s), .E_Flush(efl_s),
    .E_Hold(hold_s), .md_timeout(tmo_s), .stall_cnt(sc_s), .dbg_state_o(dbg_s)
  );

  // ---------------- reference model ----------------
  // Per instance: busy flag, MUL/DIV cycles already spent busy, sticky error, stall count.
  bit m_busy[2];
  int m_spent[2];
  bit m_to[2];
  int m_sc[2];
  int m_limit[2] = '{64, 4};
  int m_max[2]   = '{65535, 15};

  // Control outputs {PCWrite, IFIDWrite, D_Flush, E_Flush, E_Hold} from the hazard rules.
  function automatic logic [4:0] model_out(input bit busy);
    bit hazard;
    hazard = E_MemRead && (E_rd != 0) &&
             ((D_uses_rs1 && D_rs1 == E_rd) || (D_uses_rs2 && D_rs2 == E_rd));
    if (rst)             return 5'b00110;
    if (busy)            return 5'b00001;
    if (E_branch_taken)  return 5'b11110;
    if (E_md_start)      return 5'b00001;
    if (hazard)          return 5'b00010;
    if (!imem_ready)     return 5'b01100;
    return 5'b11000;
  endfunction

  task automatic model_step();
    logic [4:0] o;
    for (int k = 0; k < 2; k++) begin
      o = model_out(m_busy[k]);
      if (rst) begin
        m_busy[k] = 0; m_spent[k] = 0; m_to[k] = 0; m_sc[k] = 0;
      end else begin
        if (clr_cnt) m_sc[k] = 0;
        else if (!o[4] && m_sc[k] < m_max[k]) m_sc[k] = m_sc[k] + 1;
        if (m_busy[k]) begin
          if (md_done) m_busy[k] = 0;
          else if (m_spent[k] + 1 == m_limit[k]) begin
            m_to[k] = 1; m_busy[k] = 0;
          end else m_spent[k] = m_spent[k] + 1;
        end else if (!E_branch_taken && E_md_start) begin
          m_busy[k] = 1; m_spent[k] = 0;
        end
      end
    end
  endtask

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare both DUTs against the model at the falling edge, then advance.
  task automatic cycle();
    @(negedge clk);
    check("big ctrl",    {27'd0, pcw_l, ifidw_l, dfl_l, efl_l, hold_l}, {27'd0, model_out(m_busy[0])});
    check("big tmo",     {31'd0, tmo_l}, {31'd0, m_to[0]});
    check("big cnt",     {16'd0, sc_l}, m_sc[0]);
    check("small ctrl",  {27'd0, pcw_s, ifidw_s, dfl_s, efl_s, hold_s}, {27'd0, model_out(m_busy[1])});
    check("small tmo",   {31'd0, tmo_s}, {31'd0, m_to[1]});
    check("small cnt",   {28'd0, sc_s}, m_sc[1]);
    hold_tally_l += int'(hold_l);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst = 0; D_rs1 = 0; D_rs2 = 0; D_uses_rs1 = 0; D_uses_rs2 = 0; E_rd = 0;
    E_MemRead = 0; E_md_start = 0; md_done = 0; imem_ready = 1;
    E_branch_taken = 0; clr_cnt = 0;
  endtask

  task automatic reset_pulse();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mem, br, imem;
    logic [4:0] exp;   // {PCWrite, IFIDWrite, D_Flush, E_Flush, E_Hold}
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mem:0, br:0, imem:1, exp:5'b11000};
    vecs[1] = '{rs1:5, rs2:0, rd:5, u1:1, u2:0, mem:1, br:0, imem:1, exp:5'b00010};
    vecs[2] = '{rs1:0, rs2:0, rd:0, u1:1, u2:0, mem:1, br:0, imem:1, exp:5'b11000};
    vecs[3] = '{rs1:1, rs2:7, rd:7, u1:1, u2:1, mem:1, br:0, imem:1, exp:5'b00010};
    vecs[4] = '{rs1:9, rs2:0, rd:9, u1:0, u2:1, mem:1, br:0, imem:1, exp:5'b11000};
    vecs[5] = '{rs1:5, rs2:0, rd:5, u1:1, u2:0, mem:1, br:1, imem:1, exp:5'b11110};
    vecs[6] = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mem:0, br:0, imem:0, exp:5'b01100};
    vecs[7] = '{rs1:3, rs2:3, rd:3, u1:0, u2:1, mem:1, br:0, imem:0, exp:5'b00010};
    vecs[8] = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mem:0, br:1, imem:0, exp:5'b11110};
    vecs[9] = '{rs1:4, rs2:4, rd:4, u1:1, u2:1, mem:0, br:0, imem:1, exp:5'b11000};
  end

  // ---------------- test sequence ----------------
  initial begin
    set_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    model_step();
    #1;

    // Reset values while rst is held.
    cycle();
    check("rst ctrl", {27'd0, pcw_l, ifidw_l, dfl_l, efl_l, hold_l}, 32'b00110);
    check("rst cnt", {16'd0, sc_l}, 32'd0);
    rst = 0;

    // Vector table in RUN.
    for (int i = 0; i < 10; i++) begin
      D_rs1 = vecs[i].rs1; D_rs2 = vecs[i].rs2; E_rd = vecs[i].rd;
      D_uses_rs1 = vecs[i].u1; D_uses_rs2 = vecs[i].u2; E_MemRead = vecs[i].mem;
      E_branch_taken = vecs[i].br; imem_ready = vecs[i].imem;
      #1;
      check($sformatf("vec%0d", i), {27'd0, pcw_l, ifidw_l, dfl_l, efl_l, hold_l},
            {27'd0, vecs[i].exp});
      cycle();
    end
    set_idle();

    // Load-use gives exactly one stall count from zero.
    clr_cnt = 1; cycle(); clr_cnt = 0;
    E_MemRead = 1; E_rd = 5; D_rs1 = 5; D_uses_rs1 = 1;
    cycle();
    set_idle();
    check("load-use cnt", {16'd0, sc_l}, 32'd1);

    // MUL/DIV with md_done 5 cycles after start: big holds 6 cycles, small times out.
    reset_pulse();
    hold_tally_l = 0;
    E_md_start = 1; cycle(); E_md_start = 0;
    repeat (4) cycle();
    md_done = 1; cycle(); md_done = 0;
    cycle();
    check("md hold cycles", hold_tally_l, 32'd6);
    check("md big no tmo", {31'd0, tmo_l}, 32'd0);
    check("md big state", {31'd0, dbg_l}, 32'd0);
    check("md small tmo", {31'd0, tmo_s}, 32'd1);
    check("md small state", {31'd0, dbg_s}, 32'd0);
    repeat (5) cycle();
    check("tmo sticky", {31'd0, tmo_s}, 32'd1);
    reset_pulse();
    check("tmo cleared", {31'd0, tmo_s}, 32'd0);

    // Reset in the second MD_BUSY cycle.
    E_md_start = 1; cycle(); E_md_start = 0;
    cycle();
    rst = 1;
    #1;
    check("mid-md rst ctrl", {27'd0, pcw_s, ifidw_s, dfl_s, efl_s, hold_s}, 32'b00110);
    cycle();
    rst = 0;
    #1;
    check("post-rst state", {31'd0, dbg_l}, 32'd0);
    check("post-rst pcw", {31'd0, pcw_s}, 32'd1);
    cycle();

    // Fetch wait for 20 cycles: small counter saturates, then clears.
    clr_cnt = 1; cycle(); clr_cnt = 0;
    imem_ready = 0;
    repeat (20) cycle();
    imem_ready = 1;
    check("sat small", {28'd0, sc_s}, 32'd15);
    check("sat big", {16'd0, sc_l}, 32'd20);
    clr_cnt = 1; cycle(); clr_cnt = 0;
    check("clr small", {28'd0, sc_s}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst            = ($urandom_range(0, 59) == 0);
      D_rs1          = 5'($urandom_range(0, 7));
      D_rs2          = 5'($urandom_range(0, 7));
      E_rd           = 5'($urandom_range(0, 7));
      D_uses_rs1     = 1'($urandom_range(0, 1));
      D_uses_rs2     = 1'($urandom_range(0, 1));
      E_MemRead      = 1'($urandom_range(0, 1));
      E_md_start     = ($urandom_range(0, 5) == 0);
      md_done        = ($urandom_range(0, 6) == 0);
      imem_ready     = ($urandom_range(0, 3) != 0);
      E_branch_taken = ($urandom_range(0, 7) == 0);
      clr_cnt        = ($urandom_range(0, 39) == 0);
      cycle();
    end
    set_idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
